// File: rtl/frame_config_loader_if.sv
// Byte-stream handshake between a byte source (normally the USB CDC OUT endpoint) and
// frame_config_loader. A byte transfers on any clock edge where byte_valid and byte_ready
// are both high.
interface frame_config_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/frame_config_loader.sv
// frame_config_loader: turns a command byte stream into fabric configuration traffic.
// Assembles 32-bit little-endian frame words onto frame_data_o, pulses one FrameStrobe bit
// per word and issues APPLY_INIT pulses.
// Optional feature macro CFG_CRC_EN: every write command is followed by a CRC-8 byte
// (poly 0x07, init 0x00) covering cmd, idx, cnt and data bytes; INIT is suppressed while
// err_o is set.
module frame_config_loader #(
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned MAX_FRAMES = 21,
  parameter logic [7:0]  WR_CMD     = 8'hA5,
  parameter logic [7:0]  INIT_CMD   = 8'h5A,
  parameter logic [7:0]  CLR_CMD    = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  frame_config_loader_if.slave  byte_if,
  output logic [FRAME_BITS-1:0] frame_data_o,
  output logic [MAX_FRAMES-1:0] frame_strobe_o,
  output logic                  apply_init_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           words_o
);

`ifdef CFG_CRC_EN
  typedef enum logic [2:0] {
    StIdle, StIdx, StCnt, StData, StSetup, StStrobe, StHold, StCrc
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StIdx, StCnt, StData, StSetup, StStrobe, StHold
  } state_e;
`endif

  state_e                state_q;
  logic [7:0]            idx_q;
  logic [7:0]            cnt_q;
  logic [1:0]            bcnt_q;
  logic [23:0]           asm_q;
  logic                  dry_q;
  logic [MAX_FRAMES-1:0] strobe_dec;
  logic                  xfer;
  logic [7:0]            din;
`ifdef CFG_CRC_EN
  logic [7:0]            crc_q;

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign din  = byte_if.byte_data;
  assign xfer = byte_if.byte_valid & byte_if.byte_ready;

  // Ready only while waiting for stream bytes; the strobe sequence stalls the source.
  always_comb begin
    byte_if.byte_ready = 1'b0;
    busy_o             = (state_q != StIdle);
    unique case (state_q)
      StIdle, StIdx, StCnt, StData: byte_if.byte_ready = 1'b1;
`ifdef CFG_CRC_EN
      StCrc:                        byte_if.byte_ready = 1'b1;
`endif
      default:                      byte_if.byte_ready = 1'b0;
    endcase
  end

  // One-hot decode of the latched frame index; out-of-range indices decode to zero.
  always_comb begin
    strobe_dec = '0;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      if (idx_q == 8'(i)) strobe_dec[i] = 1'b1;
    end
  end

  // Command sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      cnt_q          <= '0;
      bcnt_q         <= '0;
      asm_q          <= '0;
      dry_q          <= 1'b0;
      frame_data_o   <= '0;
      frame_strobe_o <= '0;
      apply_init_o   <= 1'b0;
      err_o          <= 1'b0;
      words_o        <= '0;
`ifdef CFG_CRC_EN
      crc_q          <= '0;
`endif
    end else begin
      apply_init_o   <= 1'b0;
      frame_strobe_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            if (din == WR_CMD) begin
              state_q <= StIdx;
`ifdef CFG_CRC_EN
              crc_q   <= crc8(8'h00, din);
`endif
            end else if (din == INIT_CMD) begin
`ifdef CFG_CRC_EN
              apply_init_o <= ~err_o;
`else
              apply_init_o <= 1'b1;
`endif
            end else if (din == CLR_CMD) begin
              err_o <= 1'b0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        StIdx: begin
          if (xfer) begin
            idx_q   <= din;
            state_q <= StCnt;
            // An invalid index still consumes the whole command, but strobes nothing.
            if (32'(din) >= MAX_FRAMES) begin
              err_o <= 1'b1;
              dry_q <= 1'b1;
            end else begin
              dry_q <= 1'b0;
            end
`ifdef CFG_CRC_EN
            crc_q <= crc8(crc_q, din);
`endif
          end
        end
        StCnt: begin
          if (xfer) begin
            cnt_q  <= din;
            bcnt_q <= '0;
            if (din == 8'd0) begin
`ifdef CFG_CRC_EN
              state_q <= StCrc;
`else
              state_q <= StIdle;
`endif
            end else begin
              state_q <= StData;
            end
`ifdef CFG_CRC_EN
            crc_q <= crc8(crc_q, din);
`endif
          end
        end
        StData: begin
          if (xfer) begin
            bcnt_q <= bcnt_q + 2'd1;
            unique case (bcnt_q)
              2'd0: asm_q[7:0]   <= din;
              2'd1: asm_q[15:8]  <= din;
              2'd2: asm_q[23:16] <= din;
              default: begin
                frame_data_o <= {din, asm_q};
                state_q      <= StSetup;
              end
            endcase
`ifdef CFG_CRC_EN
            crc_q <= crc8(crc_q, din);
`endif
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          if (!dry_q) begin
            frame_strobe_o <= strobe_dec;
            words_o        <= words_o + 16'd1;
          end
        end
        StStrobe: begin
          cnt_q   <= cnt_q - 8'd1;
          state_q <= StHold;
        end
        StHold: begin
          if (cnt_q != 8'd0) begin
            state_q <= StData;
          end else begin
`ifdef CFG_CRC_EN
            state_q <= StCrc;
`else
            state_q <= StIdle;
`endif
          end
        end
`ifdef CFG_CRC_EN
        StCrc: begin
          if (xfer) begin
            if (din != crc_q) err_o <= 1'b1;
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_loader.sv
// Self-checking bench for frame_config_loader. Expected strobes (index, data, word count)
// are queued when a write is driven and popped by a monitor when the DUT strobes.
// Build with +define+CFG_CRC_EN to exercise the CRC variant.
module tb_frame_config_loader;
  logic        clk = 1'b0;
  logic        rstn;
  logic [20:0] frame_strobe;
  logic [31:0] frame_data;
  logic        apply_init;
  logic        busy;
  logic        err;
  logic [15:0] words;

  frame_config_loader_if bus ();

  frame_config_loader dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .byte_if        (bus.slave),
    .frame_data_o   (frame_data),
    .frame_strobe_o (frame_strobe),
    .apply_init_o   (apply_init),
    .busy_o         (busy),
    .err_o          (err),
    .words_o        (words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] data;
    logic [15:0] words;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_words = 0;
  int          init_exp = 0;
  int          init_seen = 0;
  logic        strobe_prev = 1'b0;
  logic        init_prev = 1'b0;
  logic [7:0]  crc_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
      else      r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic push_word(input logic [7:0] idx, input logic [31:0] data);
    exp_t e;
    exp_words = exp_words + 16'd1;
    e.idx   = idx;
    e.data  = data;
    e.words = exp_words;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) chk("ready_timeout", 32'(waits), 0);
    @(negedge clk);
    crc_run = crc8_model(crc_run, b);
  endtask

  task automatic send_b(input logic [7:0] b);
    int w;
    send(b, w);
  endtask

  task automatic send_crc();
`ifdef CFG_CRC_EN
    send_b(crc_run);
`endif
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.byte_valid = 1'b0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 1);
  endtask

  task automatic send_word_bytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_b(w[i*8 +: 8]);
  endtask

  // Scoreboard monitor for strobes.
  always @(negedge clk) begin
    if (frame_strobe != '0) begin
      chk("strobe_onehot", 32'($onehot(frame_strobe)), 1);
      chk("strobe_width", 32'(strobe_prev), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(frame_strobe), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_idx", 32'(frame_strobe), 32'(1) << e.idx);
        chk("strobe_data", frame_data, e.data);
        chk("strobe_words", 32'(words), 32'(e.words));
      end
    end
    strobe_prev = (frame_strobe != '0);
    if (apply_init) begin
      init_seen++;
      chk("init_width", 32'(init_prev), 0);
    end
    init_prev = apply_init;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c;
    rstn = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.byte_ready), 1);
    chk("rst_data", frame_data, 0);
    chk("rst_strobe", 32'(frame_strobe), 0);
    chk("rst_init", 32'(apply_init), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_words", 32'(words), 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single word to frame 3 with cycle-exact timing.
    crc_run = 8'h00;
    push_word(8'd3, 32'hDEADBEEF);
    send_b(8'hA5); send_b(8'h03); send_b(8'h01);
    send_word_bytes(32'hDEADBEEF);
    bus.byte_valid = 1'b0;
    chk("t1_setup_data", frame_data, 32'hDEADBEEF);
    chk("t1_setup_strobe", 32'(frame_strobe), 0);
    chk("t1_setup_ready", 32'(bus.byte_ready), 0);
    @(negedge clk);
    chk("t1_strobe", 32'(frame_strobe), 32'h8);
    @(negedge clk);
    chk("t1_hold_strobe", 32'(frame_strobe), 0);
    chk("t1_hold_data", frame_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready_back", 32'(bus.byte_ready), 1);
    send_crc();
    wait_idle();
    chk("t1_words", 32'(words), 1);
    chk("t1_err", 32'(err), 0);

    // 2: two words to frame 0, valid held high.
    crc_run = 8'h00;
    push_word(8'd0, 32'h04030201);
    push_word(8'd0, 32'h44332211);
    send_b(8'hA5); send_b(8'h00); send_b(8'h02);
    send_word_bytes(32'h04030201);
    send(8'h11, w);
    chk("t2_stall1", 32'(w), 3);
    send_b(8'h22); send_b(8'h33); send_b(8'h44);
    bus.byte_valid = 1'b0;
    c = 0;
    while (!bus.byte_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t2_stall2", 32'(c), 3);
    send_crc();
    wait_idle();
    chk("t2_words", 32'(words), 3);
    chk("t2_data_held", frame_data, 32'h44332211);

    // 3: out-of-range index runs dry; clear then INIT.
    crc_run = 8'h00;
    send_b(8'hA5); send_b(8'h15); send_b(8'h01);
    send_word_bytes(32'hCAFEF00D);
    send_crc();
    wait_idle();
    chk("t3_err", 32'(err), 1);
    chk("t3_words", 32'(words), 32'(exp_words));
    send_b(8'h00);
    bus.byte_valid = 1'b0;
    chk("t3_clr", 32'(err), 0);
    init_exp++;
    send_b(8'h5A);
    bus.byte_valid = 1'b0;
    chk("t3_init", 32'(apply_init), 1);
    @(negedge clk);
    chk("t3_init_low", 32'(apply_init), 0);

    // 4: bad command, INIT with err set, zero-length write.
    send_b(8'h33);
    bus.byte_valid = 1'b0;
    chk("t4_err", 32'(err), 1);
    send_b(8'h5A);
    bus.byte_valid = 1'b0;
`ifdef CFG_CRC_EN
    chk("t4_init_err", 32'(apply_init), 0);
`else
    init_exp++;
    chk("t4_init_err", 32'(apply_init), 1);
`endif
    crc_run = 8'h00;
    send_b(8'hA5); send_b(8'h02); send_b(8'h00);
    send_crc();
    wait_idle();
    chk("t4_n0_idle", 32'(busy), 0);
    chk("t4_n0_words", 32'(words), 32'(exp_words));
    chk("t4_err_sticky", 32'(err), 1);
    send_b(8'h00);
    bus.byte_valid = 1'b0;

`ifdef CFG_CRC_EN
    // 6: wrong CRC sets err and blocks INIT.
    crc_run = 8'h00;
    push_word(8'd3, 32'hDEADBEEF);
    send_b(8'hA5); send_b(8'h03); send_b(8'h01);
    send_word_bytes(32'hDEADBEEF);
    send_b(crc_run ^ 8'h01);
    bus.byte_valid = 1'b0;
    chk("t6_crc_err", 32'(err), 1);
    send_b(8'h5A);
    bus.byte_valid = 1'b0;
    chk("t6_init_blocked", 32'(apply_init), 0);
    send_b(8'h00);
    bus.byte_valid = 1'b0;
`endif

    // 5: reset in SETUP suppresses the strobe.
    crc_run = 8'h00;
    send_b(8'hA5); send_b(8'h04); send_b(8'h01);
    send_word_bytes(32'h12345678);
    bus.byte_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_strobe", 32'(frame_strobe), 0);
    chk("t5_data", frame_data, 0);
    chk("t5_words", 32'(words), 0);
    chk("t5_ready", 32'(bus.byte_ready), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_err", 32'(err), 0);
    rstn = 1'b1;
    exp_words = 0;
    repeat (4) @(negedge clk);
    chk("t5_no_strobe_after", 32'(words), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    chk("init_count", 32'(init_seen), 32'(init_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
